// File: rtl/gpio_responder.sv
// Device-side GPIO endpoint: synchronises and queues edge events from the agent's pins,
// and drives the agent's input pins through a delayed, masked write command.
module gpio_responder #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int DLY_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  pin_i,
  output logic [WIDTH-1:0]  pin_o,
  output logic [WIDTH-1:0]  pin_oe,
  input  logic [WIDTH-1:0]  rise_en,
  input  logic [WIDTH-1:0]  fall_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [WIDTH-1:0]  evt_value,
  output logic [WIDTH-1:0]  evt_mask,
  output logic              evt_ovf,
  input  logic              ovf_clr,
  output logic              irq,
  input  logic              irq_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  wr_oe,
  input  logic [WIDTH-1:0]  wr_mask,
  input  logic [DLY_W-1:0]  wr_delay
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [ARM_W-1:0] ARM_ONE  = 1;
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_MAX);
  localparam logic [AW-1:0]    PTR_ONE  = 1;
  localparam logic [AW:0]      CNT_ONE  = 1;
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [DLY_W-1:0] DLY_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} wr_state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_val, prev_q, edge_d, edge_q, val_q;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt == ARM_DONE);
  assign edge_d   = (sync_val & ~prev_q & rise_en) | (~sync_val & prev_q & fall_en);

  // Synchronised flops come out of reset at 0, so edges stay masked until the chain holds real pin data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      val_q   <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_val;
      edge_q <= armed ? edge_d : '0;
      val_q  <= sync_val;
      if (!armed) arm_cnt <= arm_cnt + ARM_ONE;
    end
  end

  logic [WIDTH-1:0] mem_val  [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_mask [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_req, pop, full, push_ok, drop;

  assign push_req = |edge_q;
  assign pop      = evt_valid & evt_ready;
  assign full     = (count == CNT_FULL);
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (!push_ok && pop) count <= count - CNT_ONE;
      if (drop)         evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_val[wr_ptr]  <= val_q;
      mem_mask[wr_ptr] <= edge_q;
    end
  end

  assign evt_valid = (count != '0);
  assign evt_value = evt_valid ? mem_val[rd_ptr]  : '0;
  assign evt_mask  = evt_valid ? mem_mask[rd_ptr] : '0;
  assign irq       = evt_valid & irq_en;

  wr_state_t        state_q, state_d;
  logic [DLY_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q, oe_q, mask_q, out_q, oe_out_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wr_valid) state_d = (wr_delay == '0) ? S_APPLY : S_WAIT;
      S_WAIT:  if (cnt_q <= DLY_ONE) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == S_IDLE);
  end

  // The merged pin image passes through one more flop before reaching the pads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      oe_q     <= '0;
      mask_q   <= '0;
      out_q    <= '0;
      oe_out_q <= '0;
      pin_o    <= '0;
      pin_oe   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (wr_valid) begin
          data_q <= wr_data;
          oe_q   <= wr_oe;
          mask_q <= wr_mask;
          cnt_q  <= wr_delay;
        end
        S_WAIT:  cnt_q <= cnt_q - DLY_ONE;
        S_APPLY: begin
          out_q    <= (out_q & ~mask_q) | (data_q & mask_q);
          oe_out_q <= (oe_out_q & ~mask_q) | (oe_q & mask_q);
        end
        default: ;
      endcase
      pin_o  <= out_q;
      pin_oe <= oe_out_q;
    end
  end

endmodule

// File: tb/tb_gpio_responder.sv
// Self-checking bench for gpio_responder: an edge-indexed reference model fills
// expected-event and expected-write queues; a monitor compares every cycle.
module tb_gpio_responder;

  localparam int W    = 8;
  localparam int DW   = 8;
  localparam int MAXE = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pin_i, pin_o, pin_oe, rise_en, fall_en;
  logic          evt_valid, evt_ready, evt_ovf, ovf_clr, irq, irq_en;
  logic [W-1:0]  evt_value, evt_mask;
  logic          wr_valid, wr_ready;
  logic [W-1:0]  wr_data, wr_oe, wr_mask;
  logic [DW-1:0] wr_delay;

  always #5 clk = ~clk;

  gpio_responder #(.WIDTH(W), .SYNC_STAGES(2), .FIFO_DEPTH(4), .DLY_W(DW)) dut (
    .clk(clk), .rst(rst), .pin_i(pin_i), .pin_o(pin_o), .pin_oe(pin_oe),
    .rise_en(rise_en), .fall_en(fall_en), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_value(evt_value), .evt_mask(evt_mask), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr),
    .irq(irq), .irq_en(irq_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_oe(wr_oe), .wr_mask(wr_mask), .wr_delay(wr_delay)
  );

  typedef struct { logic [W-1:0] v; logic [W-1:0] m; } evt_t;
  typedef struct { int at; logic [W-1:0] d; logic [W-1:0] o; logic [W-1:0] m; } wr_t;

  evt_t evq[$];
  wr_t  wrq[$];
  int   checks = 0;
  int   fails  = 0;
  int   e      = 0;
  int   r_edge = 0;
  int   busy_until = -1;
  logic ovf_exp = 1'b0;
  logic [W-1:0] po_exp = '0, poe_exp = '0;
  logic [W-1:0] pin_at [MAXE];
  logic [W-1:0] rise_at [MAXE];
  logic [W-1:0] fall_at [MAXE];

  logic          rst_s = 1'b1, ready_s = 1'b0, clr_s = 1'b0, wv_s = 1'b0;
  logic [W-1:0]  pin_s = '0, rise_s = '0, fall_s = '0, wd_s = '0, wo_s = '0, wm_s = '0;
  logic [DW-1:0] wdl_s = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, e, act, exp);
    end
  endtask

  // Reference model: the inputs seen at edge e are the snapshot taken at the previous negedge.
  initial begin
    forever begin
      @(negedge clk);
      e++;
      if (e < MAXE) begin
        pin_at[e]  = pin_s;
        rise_at[e] = rise_s;
        fall_at[e] = fall_s;
      end
      if (rst_s) begin
        evq.delete();
        wrq.delete();
        ovf_exp    = 1'b0;
        po_exp     = '0;
        poe_exp    = '0;
        r_edge     = e;
        busy_until = e - 1;
      end else begin
        logic         pop, push, drop;
        logic [W-1:0] cur, old, m;
        pop  = (evq.size() != 0) && ready_s;
        push = 1'b0;
        drop = 1'b0;
        m    = '0;
        cur  = '0;
        if (e >= r_edge + 5 && e < MAXE) begin
          cur = pin_at[e-3];
          old = pin_at[e-4];
          m   = (cur & ~old & rise_at[e-1]) | (~cur & old & fall_at[e-1]);
          push = (m != '0);
        end
        if (pop) void'(evq.pop_front());
        if (push) begin
          if (evq.size() < 4) evq.push_back('{v: cur, m: m});
          else drop = 1'b1;
        end
        if (drop) ovf_exp = 1'b1;
        else if (clr_s) ovf_exp = 1'b0;
        while (wrq.size() != 0 && wrq[0].at == e) begin
          po_exp  = (po_exp  & ~wrq[0].m) | (wrq[0].d & wrq[0].m);
          poe_exp = (poe_exp & ~wrq[0].m) | (wrq[0].o & wrq[0].m);
          void'(wrq.pop_front());
        end
        if (wv_s && (e - 1 > busy_until)) begin
          busy_until = e + int'(wdl_s);
          wrq.push_back('{at: e + int'(wdl_s) + 2, d: wd_s, o: wo_s, m: wm_s});
        end
      end
      checkOutput("evt_valid", 32'(evt_valid), 32'(evq.size() != 0));
      if (evq.size() != 0) begin
        checkOutput("evt_value", 32'(evt_value), 32'(evq[0].v));
        checkOutput("evt_mask",  32'(evt_mask),  32'(evq[0].m));
      end
      checkOutput("evt_ovf",  32'(evt_ovf),  32'(ovf_exp));
      checkOutput("irq",      32'(irq),      32'((evq.size() != 0) && irq_en));
      checkOutput("wr_ready", 32'(wr_ready), 32'(e > busy_until));
      checkOutput("pin_o",    32'(pin_o),    32'(po_exp));
      checkOutput("pin_oe",   32'(pin_oe),   32'(poe_exp));
      rst_s = rst; ready_s = evt_ready; clr_s = ovf_clr; wv_s = wr_valid;
      pin_s = pin_i; rise_s = rise_en; fall_s = fall_en;
      wd_s = wr_data; wo_s = wr_oe; wm_s = wr_mask; wdl_s = wr_delay;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] pins, input logic [W-1:0] rise,
                               input logic [W-1:0] fall, input logic ready, input int n);
    pin_i = pins; rise_en = rise; fall_en = fall; evt_ready = ready;
    step(n);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic doWrite(input logic [W-1:0] d, input logic [W-1:0] o,
                         input logic [W-1:0] m, input logic [DW-1:0] dl);
    logic ok;
    ok = 1'b0;
    wr_data = d; wr_oe = o; wr_mask = m; wr_delay = dl; wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    checkOutput("wr_accept", 32'(ok), 32'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; pin_i = '1; rise_en = '1; fall_en = '1; evt_ready = 1'b0;
    ovf_clr = 1'b0; irq_en = 1'b1; wr_valid = 1'b0;
    wr_data = '0; wr_oe = '0; wr_mask = '0; wr_delay = '0;
    step(3);
    rst = 1'b0;
    step(10);
    @(negedge clk);
    checkOutput("evt_value_rst", 32'(evt_value), 32'(0));
    checkOutput("evt_mask_rst",  32'(evt_mask),  32'(0));
    step(1);

    $display("[TB] rise-only capture on bit 0");
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b1, 8);
    applyStimulus(8'h01, 8'h01, 8'h00, 1'b1, 8);
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b1, 8);

    $display("[TB] fifo fill, overflow, simultaneous pop and push, clear");
    evt_ready = 1'b0; rise_en = 8'h01; fall_en = 8'h01;
    for (int i = 0; i < 5; i++) begin
      pin_i[0] = ~pin_i[0];
      step(2);
    end
    step(5);
    pin_i[0] = ~pin_i[0];
    step(3);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(4);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    applyStimulus(pin_i, 8'h01, 8'h01, 1'b1, 8);

    $display("[TB] delayed masked write");
    applyReset();
    doWrite(8'hA5, 8'hFF, 8'h0F, 8'd3);
    step(8);

    $display("[TB] back-to-back zero-delay writes");
    applyReset();
    doWrite(8'h01, 8'h01, 8'h01, 8'd0);
    doWrite(8'h02, 8'h02, 8'h02, 8'd0);
    step(6);

    $display("[TB] reset during pending write with queued events");
    applyStimulus(8'h00, 8'hFF, 8'hFF, 1'b0, 6);
    applyStimulus(8'h3C, 8'hFF, 8'hFF, 1'b0, 3);
    doWrite(8'hFF, 8'hFF, 8'hFF, 8'd20);
    step(5);
    applyReset();
    step(30);

    $display("[TB] randomized traffic");
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 3) == 0) pin_i = W'($urandom);
          if ($urandom_range(0, 15) == 0) begin
            rise_en = W'($urandom);
            fall_en = W'($urandom);
          end
          evt_ready = 1'($urandom);
          ovf_clr   = ($urandom_range(0, 15) == 0);
          irq_en    = ($urandom_range(0, 7) != 0);
          step(1);
        end
        ovf_clr = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          doWrite(W'($urandom), W'($urandom), W'($urandom), DW'($urandom_range(0, 5)));
          step($urandom_range(0, 6));
        end
      end
    join
    evt_ready = 1'b1;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gpio_responder.md
Name: gpio_responder

Overview:
- DUT-side endpoint of the GPIO agent interface.
- Receives the pins the agent drives (agent outputs) and drives the pins the agent samples (agent inputs).
- Incoming pins are synchronised, edge-qualified and queued as change events in a small FIFO with a valid/ready read port.
- Outgoing pins are updated by a masked write command applied after a programmable delay. Used as the reference responder in loopback and agent self-test benches.

Parameters:
WIDTH, 32, number of GPIO bits handled (1..1024)
SYNC_STAGES, 2, input synchroniser depth (>=2)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
DLY_W, 8, width of the write delay field

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
pin_i  input  WIDTH  pins driven by the agent (agent gpio_out)
pin_o  output  WIDTH  pin values toward the agent (agent gpio_in)
pin_oe  output  WIDTH  per-bit output enable; 0 = bit undriven (Z on the wire)
rise_en  input  WIDTH  per-bit enable for 0->1 event capture
fall_en  input  WIDTH  per-bit enable for 1->0 event capture
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts head event
evt_value  output  WIDTH  synchronised pin value at time of event
evt_mask  output  WIDTH  bits whose qualified edge caused the event
evt_ovf  output  1  sticky: an event was dropped because the FIFO was full
ovf_clr  input  1  clears evt_ovf
irq  output  1  evt_valid AND irq_en
irq_en  input  1  interrupt enable
wr_valid  input  1  write command valid
wr_ready  output  1  responder accepts a write (FSM in IDLE)
wr_data  input  WIDTH  new pin_o values
wr_oe  input  WIDTH  new pin_oe values
wr_mask  input  WIDTH  bits affected by this write
wr_delay  input  DLY_W  cycles to wait before applying

Behaviour:
- Reset state:
  - pin_o=0, pin_oe=0, evt_valid=0, evt_value=0, evt_mask=0, evt_ovf=0, irq=0, wr_ready=1.
  - FIFO emptied, synchroniser flops=0, write FSM=IDLE.
  - Reset asserted mid-operation aborts a pending write (not applied) and discards queued events.
- Input path:
  - SYNC_STAGES-flop synchroniser per bit; sync value registered again as prev.
  - edge = (sync & ~prev & rise_en) | (~sync & prev & fall_en).
  - If edge != 0, push {sync, edge} into the FIFO.
  - Latency (SYNC_STAGES=2): pin_i stable before edge k -> evt_valid high after edge k+3.
- Edge suppression after reset:
  - Detection is disabled until SYNC_STAGES+1 cycles after rst deasserts.
  - A pin_i held at 1 through reset produces no event.
- Event FIFO:
  - Pop on evt_valid && evt_ready. evt_value/evt_mask hold steady while evt_valid && !evt_ready.
  - Push when full with no pop: event dropped, evt_ovf set next cycle.
  - Push when full with a pop in the same cycle: accepted, no overflow.
  - Push when empty: visible the following cycle; no fall-through bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - ovf_clr and a new overflow in the same cycle: evt_ovf stays 1.
- Write FSM:
  - States IDLE, WAIT, APPLY; wr_ready = (state==IDLE).
  - IDLE: on wr_valid, latch data/oe/mask and load cnt=wr_delay. Go to APPLY if wr_delay==0, else WAIT.
  - WAIT: decrement cnt each cycle; go to APPLY when cnt reaches 1.
  - APPLY:
    - pin_o <= (pin_o & ~mask) | (data & mask)
    - pin_oe <= (pin_oe & ~mask) | (oe & mask)
    - then go to IDLE.
  - Visible output change occurs wr_delay+2 edges after the accepting edge (delay 0 -> 2 edges).
  - Back-to-back writes: the next write is accepted in the cycle after APPLY.
  - mask=0: FSM runs the full sequence, outputs unchanged.
- irq is combinational from registered evt_valid and irq_en.

Test Plan:
- Reset with pin_i=all 1s, release, wait 10 cycles -> no evt_valid; all outputs at reset values.
- rise_en=0x1, pin_i 0->0x1 at cycle 10, evt_ready=1 -> one event, evt_value=0x1, evt_mask=0x1, at cycle 13. Falling back to 0 -> no event.
- evt_ready=0, 5 qualified toggles on bit 0 -> 4 events held, evt_ovf=1. Pop one while a 6th edge arrives -> accepted, FIFO full again. ovf_clr -> evt_ovf=0.
- Write data=0xA5, oe=0xFF, mask=0x0F, delay=3 from reset -> pin_o=0x05, pin_oe=0x0F exactly 5 edges after acceptance; wr_ready low for 4 cycles.
- Two writes back-to-back with delay 0 (mask 0x1 then 0x2) -> second accepted in the cycle after the first APPLY; pin_o=0x3 at the end.
- Assert rst during WAIT with delay=20 -> pin_o stays 0, wr_ready=1 the cycle after reset; queued events cleared.
